call_request_latch: RTL
=======================

CALL_REQUEST_LATCH -- requirements
Module: call_request_latch

Interface
REQ-001 SHALL have parameter FLOORS, default 4: number of call buttons (2..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a level change (1..255).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port buttons  input  FLOORS  raw asynchronous call buttons, bit i = floor i, 1 = pressed.
REQ-006 SHALL have port serve_valid  input  1  synchronous strobe: the car has served serve_floor this cycle.
REQ-007 SHALL have port serve_floor  input  $clog2(FLOORS)  index of the floor being served.
REQ-008 SHALL have port press_pulse  output  FLOORS  one-cycle pulse per accepted press.
REQ-009 SHALL have port pending  output  FLOORS  latched outstanding call per floor.
REQ-010 SHALL have port any_pending  output  1  OR of all pending bits.

Function
REQ-011 SHALL pass each buttons bit through two series flops (sync1, sync2) before any other use.
REQ-012 SHALL keep, per floor, a debounced level deb[i] and a counter cnt[i] of width $clog2(DEBOUNCE_CYCLES+1).
REQ-013 SHALL compare sync2[i] with deb[i] on every edge:
- equal: cnt[i] <= 0.
- unequal and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] increments.
- unequal and cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= sync2[i] and cnt[i] <= 0.
REQ-014 SHALL discard any mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles: cnt[i] returns to 0 and deb[i] is unchanged.
REQ-015 SHALL register press_pulse[i] high for exactly one cycle, on the same edge where deb[i] goes 0->1; a deb 1->0 transition produces no pulse.
REQ-016 SHALL make the latency fixed: with buttons[i] first sampled high at edge E1 and held high, press_pulse[i] and pending[i] go high after edge E(DEBOUNCE_CYCLES+2).
REQ-017 SHALL set pending[i] on the edge where press_pulse[i] asserts; pending[i] stays set while the button is held or released until it is served.
REQ-018 SHALL clear pending[i] on an edge where serve_valid=1 and serve_floor==i, provided no new press for floor i is accepted on that edge.
REQ-019 SHALL keep pending[i] set when a clear for floor i and a new press for floor i occur on the same edge (set wins).
REQ-020 SHALL ignore serve_valid when serve_floor >= FLOORS: no pending bit changes.
REQ-021 SHALL leave pending[i] unchanged when a press arrives while it is already set; press_pulse still fires.
REQ-022 SHALL process all floors independently and concurrently; simultaneous presses on several floors each produce their own pulse on the same edge.
REQ-023 SHALL drive any_pending combinationally from the registered pending bits.
REQ-024 SHALL make all outputs except any_pending direct register outputs.

Reset
REQ-025 SHALL, while reset=0, asynchronously force sync1, sync2, deb, cnt, press_pulse and pending to 0, and hence any_pending to 0.
REQ-026 SHALL treat a reset asserted mid-debounce or mid-pulse as a full abort: no pulse completes and no pending bit survives.
REQ-027 SHALL treat a button held through reset release as a new press: after reset releases, it is debounced from deb=0 and pulses per REQ-016.

Verification (FLOORS=4, DEBOUNCE_CYCLES=4)
REQ-028 SHALL cover a clean press: buttons=0001 held from E1 -> press_pulse=0001 for exactly one cycle after E6; pending=0001 and any_pending=1 from E6.
REQ-029 SHALL cover glitch rejection: buttons[2] high for 3 cycles, then low -> press_pulse stays 0 and pending stays 0000.
REQ-030 SHALL cover serve: with pending=0101, serve_valid=1 and serve_floor=2 for one cycle -> pending=0001 next cycle; then serve_floor=0 -> pending=0000 and any_pending=0.
REQ-031 SHALL cover set-over-clear collision: serve_valid=1 and serve_floor=1 on the same edge that floor 1's press is accepted -> pending[1]=1.
REQ-032 SHALL cover an out-of-range serve: FLOORS=3 build, serve_floor=3 with serve_valid=1 -> pending unchanged.
REQ-033 SHALL cover reset: reset=0 mid-debounce on floor 3 with pending=0011 -> all outputs 0 immediately; button still held after release -> pulse on floor 3 six edges after release.

Source files
------------

// File: rtl/call_request_latch.sv
// call_request_latch
// Synchronises and debounces one call button per floor, emits a one-cycle
// pulse for every accepted press and latches an outstanding call until the
// car reports that floor as served.
//
// Serve interface: serve_valid is a strobe with no back-pressure. When it is
// high on a rising edge of clock, serve_floor is taken as the floor served in
// that cycle. There is no ready; the block always accepts the strobe. A
// serve_floor outside 0..FLOORS-1 is ignored.
module call_request_latch #(
  parameter int FLOORS          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [FLOORS-1:0]         buttons,
  input  logic                      serve_valid,
  input  logic [$clog2(FLOORS)-1:0] serve_floor,
  output logic [FLOORS-1:0]         press_pulse,
  output logic [FLOORS-1:0]         pending,
  output logic                      any_pending
);

  localparam int SW = $clog2(FLOORS);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [FLOORS-1:0] sync1;
  logic [FLOORS-1:0] sync2;
  logic [FLOORS-1:0] deb;
  logic [CW-1:0]     cnt [FLOORS];

  // Combinational decode of this edge's events, per floor.
  logic [FLOORS-1:0] accept_rise;
  logic [FLOORS-1:0] serve_hit;

  // Two-flop synchroniser on the raw button inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
    end
  end

  // Per-floor debounce: a level change is adopted only after it has been
  // seen on DEBOUNCE_CYCLES consecutive edges; any shorter run is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < FLOORS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FLOORS; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Decode, per floor, whether a 0->1 debounce completes on this edge and
  // whether a valid in-range serve addresses this floor.
  always_comb begin
    accept_rise = '0;
    serve_hit   = '0;
    for (int i = 0; i < FLOORS; i++) begin
      accept_rise[i] = sync2[i] & ~deb[i] & (cnt[i] == CNT_LAST);
      serve_hit[i]   = serve_valid && (int'(serve_floor) < FLOORS) &&
                       (serve_floor == SW'(i));
    end
  end

  // Press pulse and call latch; a press accepted on the same edge as a
  // serve for that floor keeps the call outstanding.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      press_pulse <= '0;
      pending     <= '0;
    end else begin
      press_pulse <= accept_rise;
      pending     <= accept_rise | (pending & ~serve_hit);
    end
  end

  // Summary flag derived from the registered call bits.
  always_comb begin
    any_pending = |pending;
  end

endmodule
